xdma_desc_byp_arbiter: RTL and testbench

//  Shares one XDMA descriptor-bypass channel (h2c or c2h; one instance per direction) among NUM_REQ requesters.

---
 rtl/xdma_byp_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/xdma_desc_byp_arbiter.sv | 138 +++++++++++++
 tb/tb_xdma_desc_byp_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_byp_pkg.sv
// Shared definitions for the XDMA descriptor-bypass paths.
package xdma_byp_pkg;

   localparam int BYP_ADDR_W   = 64;
   localparam int BYP_LEN_W    = 28;
   localparam int BYP_CTL_W    = 5;
   // Bit of the XDMA *_sts bus that pulses once per finished descriptor.
   localparam int STS_DONE_BIT = 3;

   typedef struct packed {
      logic [BYP_ADDR_W-1:0] src;
      logic [BYP_ADDR_W-1:0] dst;
      logic [BYP_LEN_W-1:0]  len;
      logic [BYP_CTL_W-1:0]  ctl;
   } byp_desc_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } byp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// scanning circularly. The pointer moves past the winner only on advance.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] cand;
   int               j;

   // Circular priority scan; walking downward lets the closest requester win.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      j         = 0;
      if (en) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = IDX_W'(j);
            if (req[cand]) begin
               grant       = '0;
               grant[cand] = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   // Pointer moves to the slot just after the winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance) begin
         if (grant_idx == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
         else                                  rr_ptr <= grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/xdma_desc_byp_arbiter.sv
// Shares one XDMA descriptor-bypass channel among NUM_REQ requesters:
// round-robin grant, one registered issue stage, outstanding limit and
// in-order routing of descriptor-done pulses back to the issuer.
module xdma_desc_byp_arbiter
   import xdma_byp_pkg::*;
#(
   parameter  int NUM_REQ         = 4,
   parameter  int MAX_OUTSTANDING = 8,
   parameter  int ADDR_WIDTH      = BYP_ADDR_W,
   parameter  int LEN_WIDTH       = BYP_LEN_W,
   parameter  int CTL_WIDTH       = BYP_CTL_W,
   localparam int ID_WIDTH        = $clog2(NUM_REQ),
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   input  logic [NUM_REQ*CTL_WIDTH-1:0]  req_ctl,
   output logic                          done_valid,
   output logic [ID_WIDTH-1:0]           done_id,
   output logic                          byp_load,
   input  logic                          byp_ready,
   output logic [ADDR_WIDTH-1:0]         byp_src_addr,
   output logic [ADDR_WIDTH-1:0]         byp_dst_addr,
   output logic [LEN_WIDTH-1:0]          byp_len,
   output logic [CTL_WIDTH-1:0]          byp_ctl,
   input  logic                          byp_desc_done,
   output logic [CNT_W-1:0]              outstanding,
   output logic                          err_spurious
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);

   byp_state_t              state, state_nxt;
   logic [NUM_REQ-1:0]      grant;
   logic [ID_WIDTH-1:0]     grant_idx;
   logic                    grant_en, grant_any;
   logic                    push, pop;

   logic [ADDR_WIDTH-1:0]   src_p1, dst_p1;
   logic [LEN_WIDTH-1:0]    len_p1;
   logic [CTL_WIDTH-1:0]    ctl_p1;
   logic [ID_WIDTH-1:0]     id_p1;

   logic [ID_WIDTH-1:0]     id_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;

   // The descriptor sitting in ISSUE already counts against the limit.
   assign grant_en  = !RST && (state == ST_IDLE) &&
                      (({1'b0, outstanding} + (CNT_W+1)'(state == ST_ISSUE)) <
                       (CNT_W+1)'(MAX_OUTSTANDING));
   assign grant_any = |grant;
   assign req_ready = grant;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk       (CLK),
      .rst       (RST),
      .req       (req_valid),
      .en        (grant_en),
      .advance   (grant_any),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Next state: capture on grant, release once the IP accepts.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_any) state_nxt = ST_ISSUE;
         ST_ISSUE: if (byp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---- issue stage (p1): fields held stable while byp_load waits ----
   // Capture the winner's descriptor; data path is not reset.
   always_ff @(posedge CLK) begin
      if (grant_any) begin
         src_p1 <= req_src_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         dst_p1 <= req_dst_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         len_p1 <= req_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
         ctl_p1 <= req_ctl[int'(grant_idx)*CTL_WIDTH +: CTL_WIDTH];
         id_p1  <= grant_idx;
      end
   end

   // Outputs are gated by state so they read zero whenever nothing is offered.
   assign byp_load     = (state == ST_ISSUE);
   assign byp_src_addr = byp_load ? src_p1 : '0;
   assign byp_dst_addr = byp_load ? dst_p1 : '0;
   assign byp_len      = byp_load ? len_p1 : '0;
   assign byp_ctl      = byp_load ? ctl_p1 : '0;

   assign push = byp_load && byp_ready;
   assign pop  = byp_desc_done && (outstanding != '0);

   // ---- completion stage: ID FIFO tracks issue order ----
   // ID storage; occupancy is tracked by the outstanding counter.
   always_ff @(posedge CLK) begin
      if (push) id_fifo[wr_ptr] <= id_p1;
   end

   // Control state, pointers, counter and completion/error flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= ST_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         outstanding  <= '0;
         done_valid   <= 1'b0;
         done_id      <= '0;
         err_spurious <= 1'b0;
      end else begin
         state      <= state_nxt;
         done_valid <= pop;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            done_id <= id_fifo[rd_ptr];
         end
         case ({push, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (byp_desc_done && (outstanding == '0)) err_spurious <= 1'b1;
      end
   end

   // A push into a full FIFO would mean the grant limit was bypassed.
   assert property (@(posedge CLK) disable iff (RST)
      !(push && !pop && (outstanding == CNT_W'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_xdma_desc_byp_arbiter.sv
// Directed self-checking bench for xdma_desc_byp_arbiter.
module tb_xdma_desc_byp_arbiter;

   localparam int NR = 4;
   localparam int AW = 64;
   localparam int LW = 28;
   localparam int CW = 5;
   localparam int IW = 2;
   localparam int OW = 4;

   logic               CLK = 1'b0;
   logic               RST;
   logic [NR-1:0]      req_valid, req_ready;
   logic [NR*AW-1:0]   req_src_addr, req_dst_addr;
   logic [NR*LW-1:0]   req_len;
   logic [NR*CW-1:0]   req_ctl;
   logic               done_valid;
   logic [IW-1:0]      done_id;
   logic               byp_load, byp_ready;
   logic [AW-1:0]      byp_src_addr, byp_dst_addr;
   logic [LW-1:0]      byp_len;
   logic [CW-1:0]      byp_ctl;
   logic               byp_desc_done;
   logic [OW-1:0]      outstanding;
   logic               err_spurious;

   int n_checks = 0;
   int n_fail   = 0;

   xdma_desc_byp_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(8)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_src_addr  (req_src_addr),
      .req_dst_addr  (req_dst_addr),
      .req_len       (req_len),
      .req_ctl       (req_ctl),
      .done_valid    (done_valid),
      .done_id       (done_id),
      .byp_load      (byp_load),
      .byp_ready     (byp_ready),
      .byp_src_addr  (byp_src_addr),
      .byp_dst_addr  (byp_dst_addr),
      .byp_len       (byp_len),
      .byp_ctl       (byp_ctl),
      .byp_desc_done (byp_desc_done),
      .outstanding   (outstanding),
      .err_spurious  (err_spurious)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change 2 time units after the active edge; outputs are read there too.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic set_fields(input int i, input logic [63:0] src, input logic [63:0] dst,
                             input logic [27:0] len, input logic [4:0] ctl);
      req_src_addr[i*AW +: AW] = src;
      req_dst_addr[i*AW +: AW] = dst;
      req_len[i*LW +: LW]      = len;
      req_ctl[i*CW +: CW]      = ctl;
   endtask

   task automatic do_reset();
      RST           = 1'b1;
      req_valid     = '0;
      byp_ready     = 1'b0;
      byp_desc_done = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_src_addr = '0;
      req_dst_addr = '0;
      req_len      = '0;
      req_ctl      = '0;
      do_reset();
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_byp_load", byp_load, 0);
      check_eq("rst_byp_src", byp_src_addr, 0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_err", err_spurious, 0);
      check_eq("rst_done_valid", done_valid, 0);

      // 1: single descriptor round trip
      set_fields(0, 64'h1000, 64'h2000, 28'd64, 5'h13);
      req_valid = 4'b0001;
      byp_ready = 1'b1;
      #1;
      check_eq("t1_req_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      #1;
      check_eq("t1_load", byp_load, 1);
      check_eq("t1_src", byp_src_addr, 64'h1000);
      check_eq("t1_dst", byp_dst_addr, 64'h2000);
      check_eq("t1_len", byp_len, 64);
      check_eq("t1_ctl", byp_ctl, 5'h13);
      check_eq("t1_rdy_issue", req_ready, 0);
      tick();
      check_eq("t1_load_off", byp_load, 0);
      check_eq("t1_outst1", outstanding, 1);
      byp_desc_done = 1'b1;
      tick();
      byp_desc_done = 1'b0;
      check_eq("t1_done_valid", done_valid, 1);
      check_eq("t1_done_id", done_id, 0);
      check_eq("t1_outst0", outstanding, 0);
      tick();
      check_eq("t1_done_pulse", done_valid, 0);

      // 2: fairness with all requesters held valid
      do_reset();
      for (int i = 0; i < NR; i++)
         set_fields(i, 64'hA000 + 64'(i), 64'hB000 + 64'(i), 28'(16 * (i + 1)), 5'(i));
      req_valid = '1;
      byp_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         check_eq("t2_grant", req_ready, 64'(1) << (k % 4));
         byp_desc_done = (k > 0);
         tick();
         byp_desc_done = 1'b0;
         #1;
         check_eq("t2_src", byp_src_addr, 64'hA000 + 64'(k % 4));
         check_eq("t2_rdy_issue", req_ready, 0);
         check_eq("t2_done_valid", done_valid, (k > 0));
         if (k > 0) check_eq("t2_done_id", done_id, 64'((k - 1) % 4));
         tick();
      end
      check_eq("t2_outst", outstanding, 1);

      // 3: backpressure holds the issue stage stable
      do_reset();
      set_fields(1, 64'h3000, 64'h4000, 28'd128, 5'h1f);
      req_valid = 4'b0010;
      byp_ready = 1'b0;
      #1;
      check_eq("t3_grant", req_ready, 4'b0010);
      tick();
      req_valid = 4'b1101;
      #1;
      for (int c = 0; c < 5; c++) begin
         check_eq("t3_load", byp_load, 1);
         check_eq("t3_src", byp_src_addr, 64'h3000);
         check_eq("t3_dst", byp_dst_addr, 64'h4000);
         check_eq("t3_len", byp_len, 128);
         check_eq("t3_rdy", req_ready, 0);
         check_eq("t3_outst0", outstanding, 0);
         if (c < 4) tick();
      end
      byp_ready = 1'b1;
      req_valid = '0;
      tick();
      check_eq("t3_outst1", outstanding, 1);
      check_eq("t3_load_off", byp_load, 0);
      tick();
      check_eq("t3_outst_hold", outstanding, 1);

      // 4: outstanding limit of 8
      do_reset();
      set_fields(0, 64'h5000, 64'h6000, 28'd0, 5'h0);
      req_valid = 4'b0001;
      byp_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         check_eq("t4_grant", req_ready, 1);
         tick();
         check_eq("t4_len0", byp_len, 0);
         tick();
      end
      check_eq("t4_outst8", outstanding, 8);
      check_eq("t4_blocked", req_ready, 0);
      tick();
      check_eq("t4_no_load", byp_load, 0);
      check_eq("t4_still_blocked", req_ready, 0);
      byp_desc_done = 1'b1;
      tick();
      byp_desc_done = 1'b0;
      #1;
      check_eq("t4_done", done_valid, 1);
      check_eq("t4_outst7", outstanding, 7);
      check_eq("t4_ninth_grant", req_ready, 1);
      tick();
      req_valid = '0;
      check_eq("t4_ninth_load", byp_load, 1);
      tick();
      check_eq("t4_outst8b", outstanding, 8);

      // 5: in-order completion with a coincident push and pop
      do_reset();
      set_fields(0, 64'h7000, 64'h7100, 28'd1, 5'h1);
      set_fields(2, 64'h7200, 64'h7300, 28'd2, 5'h2);
      set_fields(3, 64'h7400, 64'h7500, 28'd3, 5'h3);
      byp_ready = 1'b1;
      req_valid = 4'b0100;
      #1;
      check_eq("t5_grant2", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      tick();
      check_eq("t5_outst1", outstanding, 1);
      req_valid = 4'b0001;
      #1;
      check_eq("t5_grant0", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      check_eq("t5_outst2", outstanding, 2);
      req_valid = 4'b1000;
      #1;
      check_eq("t5_grant3", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      byp_desc_done = 1'b1;
      #1;
      check_eq("t5_load3", byp_load, 1);
      check_eq("t5_src3", byp_src_addr, 64'h7400);
      tick();
      check_eq("t5_outst_simul", outstanding, 2);
      check_eq("t5_dv_a", done_valid, 1);
      check_eq("t5_id_a", done_id, 2);
      tick();
      check_eq("t5_outst_b", outstanding, 1);
      check_eq("t5_dv_b", done_valid, 1);
      check_eq("t5_id_b", done_id, 0);
      tick();
      byp_desc_done = 1'b0;
      check_eq("t5_outst_c", outstanding, 0);
      check_eq("t5_dv_c", done_valid, 1);
      check_eq("t5_id_c", done_id, 3);
      tick();
      check_eq("t5_dv_end", done_valid, 0);
      check_eq("t5_err", err_spurious, 0);

      // 6: spurious completion and reset during ISSUE
      byp_desc_done = 1'b1;
      tick();
      byp_desc_done = 1'b0;
      check_eq("t6_err_set", err_spurious, 1);
      check_eq("t6_no_done", done_valid, 0);
      check_eq("t6_outst0", outstanding, 0);
      byp_ready = 1'b1;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      check_eq("t6_outst1", outstanding, 1);
      byp_ready = 1'b0;
      req_valid = 4'b0100;
      tick();
      check_eq("t6_issue", byp_load, 1);
      RST = 1'b1;
      tick();
      check_eq("t6_rst_load", byp_load, 0);
      check_eq("t6_rst_outst", outstanding, 0);
      check_eq("t6_rst_err", err_spurious, 0);
      check_eq("t6_rst_rdy", req_ready, 0);
      check_eq("t6_rst_src", byp_src_addr, 0);
      RST = 1'b0;
      req_valid = '0;
      byp_desc_done = 1'b1;
      tick();
      byp_desc_done = 1'b0;
      check_eq("t6_late_err", err_spurious, 1);
      check_eq("t6_late_done", done_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
